// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package debounce_pkg;

  // Debounce FSM: two stable states, each with a qualifying check state.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff
  import debounce_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw level through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizer, stable-sample counter and a
// four-state FSM producing a debounced level and a one-cycle press strobe.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic pulse,
  output logic level
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             w_b_s;
  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic             r_pulse,  w_pulse_nxt;
  logic             r_level,  w_level_nxt;

  // ---- stage 0: synchronize the raw button into the clk domain ----
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (button),
    .q       (w_b_s)
  );

  // ---- stage 1: next-state decode from the synchronized sample ----
  // Next state, counter and outputs; the counter counts consecutive
  // samples that disagree with the current debounced level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_level_nxt = r_level;
    unique case (r_state)
      RELEASED: begin
        if (w_b_s) begin
          w_state_nxt = PRESS_CHK;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!w_b_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_pulse_nxt = 1'b1;
          w_level_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!w_b_s) begin
          w_state_nxt = RELEASE_CHK;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        if (w_b_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = RELEASED;
          w_level_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---- stage 2: registered state, counter and outputs ----
  // Register FSM state, counter and outputs; reset discards all progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign pulse = r_pulse;
  assign level = r_level;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a per-cycle scoreboard.
module tb_button_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic reset_n;
  logic button;
  logic pulse;
  logic level;

  int total;
  int bad;

  // reference model state
  logic [SYNC-1:0] m_sync;
  int              m_run;
  logic            m_lvl;
  logic            m_pls;
  logic [1:0]      exp_q[$];

  // per-scenario observations
  int   edge_no;
  int   npulse;
  int   first_pulse;
  int   lvl_edge;
  logic prev_lvl;

  button_debouncer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .button  (button),
    .pulse   (pulse),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic start_scn();
    edge_no     = 0;
    npulse      = 0;
    first_pulse = 0;
    lvl_edge    = 0;
    prev_lvl    = level;
  endtask

  // One clock: drive inputs, predict outputs, then compare after the edge.
  task automatic tick(input logic b, input logic rn);
    logic       bs;
    logic [1:0] e;
    button  = b;
    reset_n = rn;
    if (!rn) begin
      m_sync = '0;
      m_run  = 0;
      m_lvl  = 1'b0;
      m_pls  = 1'b0;
    end else begin
      bs    = m_sync[SYNC-1];
      m_pls = 1'b0;
      if (bs != m_lvl) begin
        m_run++;
        if (m_run == STABLE) begin
          m_lvl = bs;
          m_pls = bs;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_sync = {m_sync[SYNC-2:0], b};
    end
    exp_q.push_back({m_pls, m_lvl});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    edge_no++;
    total++;
    assert (pulse === e[1]) else begin
      bad++;
      $error("FAIL sb_pulse edge %0d: got %b want %b", edge_no, pulse, e[1]);
    end
    total++;
    assert (level === e[0]) else begin
      bad++;
      $error("FAIL sb_level edge %0d: got %b want %b", edge_no, level, e[0]);
    end
    if (pulse === 1'b1) begin
      npulse++;
      if (first_pulse == 0) first_pulse = edge_no;
    end
    if (level !== prev_lvl && lvl_edge == 0) lvl_edge = edge_no;
    prev_lvl = level;
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b1);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    button  = 1'b1;
    reset_n = 1'b0;
    m_sync  = '0;
    m_run   = 0;
    m_lvl   = 1'b0;
    m_pls   = 1'b0;

    // Reset held two cycles with button high
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_level", int'(level), 0);

    // Button already high when reset releases
    start_scn();
    hold(1'b1, 10);
    chk("post_rst_pulse_edge", first_pulse, 6);
    chk("post_rst_npulse", npulse, 1);
    chk("post_rst_level", int'(level), 1);
    start_scn();
    hold(1'b0, 10);
    chk("post_rst_fall_edge", lvl_edge, 6);
    chk("post_rst_rel_npulse", npulse, 0);

    // Clean press and release
    start_scn();
    hold(1'b1, 10);
    chk("clean_pulse_edge", first_pulse, 6);
    chk("clean_rise_edge", lvl_edge, 6);
    chk("clean_npulse", npulse, 1);
    start_scn();
    hold(1'b0, 10);
    chk("clean_fall_edge", lvl_edge, 6);
    chk("clean_rel_npulse", npulse, 0);
    chk("clean_level_low", int'(level), 0);

    // Bounce 1,0,1,0 then held high; final rise is at edge 5
    start_scn();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    hold(1'b1, 10);
    chk("bounce_npulse", npulse, 1);
    chk("bounce_pulse_edge", first_pulse, 10);
    hold(1'b0, 10);

    // Press glitch of 3 cycles
    start_scn();
    hold(1'b1, 3);
    hold(1'b0, 8);
    chk("glitch_npulse", npulse, 0);
    chk("glitch_level", int'(level), 0);
    chk("glitch_lvl_edge", lvl_edge, 0);

    // Release glitch of 3 cycles while pressed
    hold(1'b1, 10);
    chk("relglitch_setup_level", int'(level), 1);
    start_scn();
    hold(1'b0, 3);
    hold(1'b1, 8);
    chk("relglitch_npulse", npulse, 0);
    chk("relglitch_level", int'(level), 1);
    chk("relglitch_lvl_edge", lvl_edge, 0);
    hold(1'b0, 10);

    // Reset mid-check (PRESS_CHK with cnt=2 after four high edges)
    start_scn();
    hold(1'b1, 4);
    tick(1'b1, 1'b0);
    chk("midrst_npulse_pre", npulse, 0);
    start_scn();
    hold(1'b1, 10);
    chk("midrst_pulse_edge", first_pulse, 6);
    chk("midrst_npulse", npulse, 1);
    hold(1'b0, 10);

    // Long hold: no auto-repeat
    start_scn();
    hold(1'b1, 100);
    chk("held_npulse", npulse, 1);
    chk("held_pulse_edge", first_pulse, 6);
    hold(1'b0, 10);
    chk("held_level_low", int'(level), 0);

    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
